m68k_bus_target: RTL
====================

# m68k_bus_target

Single-clock 68000 bus responder: the target side of the asynchronous 68K bus cycle that the PiStorm bus master initiates. It decodes AS/UDS/LDS/RW/FC/address against a parameterised window and serves an 8×16-bit register bank with byte-lane writes. It answers with DTACK after a programmable number of 7 MHz wait states, or with BERR for illegal accesses. It is used as an on-board loopback target and bench responder for the master path.

## Interface

- `BASE_ADDR`, default 24'hDFF000: window base; bits [23:4] are compared.
- `WAIT_STATES`, default 2: c7m falling edges between cycle acceptance and DTACK assertion (0–15).
- `ID_VALUE`, default 16'h5354: read-only contents of register 7.
- `TIMEOUT`, default 255: PI_CLK cycles allowed in HOLD before a forced release.

- `PI_CLK` in 1: sole clock (~200 MHz); every flop is on its rising edge.
- `SYS_RESET` in 1: synchronous, active-high reset.
- `M68K_CLK` in 1: 7 MHz bus clock; sampled only, through a 3-flop synchroniser.
- `M68K_AS_n`, `M68K_UDS_n`, `M68K_LDS_n`, `M68K_RW` in 1 each: bus strobes; 2-flop synchronised.
- `M68K_FC` in 3: function code. FC=3'b111 (interrupt acknowledge) is never claimed.
- `M68K_A` in 23: address A[23:1].
- `M68K_D` inout 16: data bus; driven only while `D_OE`=1, otherwise Z.
- `M68K_DTACK_n` out 1: data acknowledge.
- `M68K_BERR_n` out 1: bus error.
- `D_OE` out 1: read data drive enable.
- `REGS` out 128: register bank, reg n at [16n+15:16n].
- `WR_STROBE` out 8: one-hot, pulses one PI_CLK cycle when reg n is written.
- `BUSY` out 1: high from ACCEPT until return to IDLE.

## Operation

- Reset values:
  - `M68K_DTACK_n`=1, `M68K_BERR_n`=1, `D_OE`=0.
  - REGS regs 0–6 = 0; reg 7 = ID_VALUE.
  - `WR_STROBE`=0, `BUSY`=0, wait counter = 0, state = IDLE.
- Hit condition: AS_n low (synchronised), A[23:4]==BASE_ADDR[23:4], and FC≠3'b111. Register index is A[3:1].
- States:
  - **IDLE**: on a sync AS_n falling edge with a hit, go to ACCEPT. A non-hit is ignored; outputs stay released.
  - **ACCEPT**: one cycle. Latch index, RW, UDS_n and LDS_n. Load counter = WAIT_STATES. Set `BUSY`. A write to reg 7 goes to ERROR; all other accesses go to WAIT.
  - **WAIT**: decrement the counter on each c7m falling edge. When the counter reaches 0 (immediately if WAIT_STATES=0), go to ACK.
    - Read: `D_OE`=1 from WAIT entry. Drive reg[index] on both lanes regardless of UDS/LDS.
    - Write: in the cycle ACK is entered, capture `M68K_D` (synchronised at that point). Update [15:8] only if UDS_n=0 and [7:0] only if LDS_n=0, then pulse `WR_STROBE[index]`.
  - **ACK**: `M68K_DTACK_n`=0. Go to HOLD.
  - **ERROR**: `M68K_BERR_n`=0, no register change, no strobe. Go to HOLD.
  - **HOLD**: keep DTACK/BERR as set. Wait for sync AS_n high, or TIMEOUT PI_CLK cycles, whichever comes first. Then release DTACK, BERR and `D_OE` in the same cycle, clear `BUSY`, and return to IDLE.
- Both strobes high at ACCEPT (AS without data strobes): treat as a write with no lanes. DTACK is still issued; the strobe still pulses.
- AS_n rising before HOLD (master abort): return to IDLE next cycle. Release all outputs, perform no write, pulse no strobe.
- `SYS_RESET` mid-cycle: all outputs go to their reset values on the next edge. No bus recovery is needed; the master times out or sees BERR from elsewhere.
- Back-to-back cycles: a new AS falling edge is recognised only after IDLE has been re-entered.

## Timing

- Synchroniser latency: 2 PI_CLK for strobes; 3 PI_CLK for M68K_CLK edges.
- DTACK assertion: ACCEPT + WAIT_STATES c7m falling edges + 1 PI_CLK, measured from the synchronised AS edge.
- Minimum (WAIT_STATES=0): AS_n low at the pin → DTACK low in 5 PI_CLK.
- Read data is valid on `M68K_D` at least one full WAIT cycle before DTACK falls.
- DTACK, BERR and `D_OE` release 3 PI_CLK after the AS_n pin rises. This sits well inside the master's S7→S0 gap.
- `WR_STROBE` width: exactly 1 PI_CLK, coincident with the REGS update being visible.

## Test plan

- Reset, then write 16'hA55A to BASE+2 with both strobes, WAIT_STATES=2 → DTACK after 2 c7m falls; REGS[31:16]=16'hA55A; `WR_STROBE`=8'h02 for 1 cycle; DTACK releases ≤3 cycles after AS high.
- Byte write 16'h12xx to BASE+4 with UDS only, reg 2 previously 16'hFFFF → reg 2 = 16'h12FF. Then LDS-only 16'hxx34 → 16'h1234.
- Read BASE+14 → `D_OE`=1 with `M68K_D`=ID_VALUE before DTACK. Write BASE+14 → BERR_n=0, DTACK_n stays 1, reg 7 unchanged, no strobe.
- Access at BASE+16, and at BASE+0 with FC=3'b111 → no output change at all; `BUSY` stays 0.
- Abort: AS_n rises during WAIT on a write → no register change, no strobe, IDLE next cycle. Stuck AS_n low → forced release after TIMEOUT=255 cycles.
- Assert `SYS_RESET` while in ACK → next edge DTACK_n=1, `D_OE`=0, REGS cleared with reg 7 = ID_VALUE, state IDLE.

Source files
------------

// File: rtl/m68k_bus_target.sv
// rtl/m68k_bus_target.sv - 68000 bus target: windowed register bank with wait states, DTACK and BERR
`timescale 1ns/1ps
module m68k_bus_target #(
   parameter logic [23:0] BASE_ADDR   = 24'hDFF000,
   parameter int          WAIT_STATES = 2,
   parameter logic [15:0] ID_VALUE    = 16'h5354,
   parameter int          TIMEOUT     = 255
) (
   input  logic           PI_CLK,
   input  logic           SYS_RESET,
   input  logic           M68K_CLK,
   input  logic           M68K_AS_n,
   input  logic           M68K_UDS_n,
   input  logic           M68K_LDS_n,
   input  logic           M68K_RW,
   input  logic [2:0]     M68K_FC,
   input  logic [23:1]    M68K_A,
   inout  wire  [15:0]    M68K_D,
   output logic           M68K_DTACK_n,
   output logic           M68K_BERR_n,
   output logic           D_OE,
   output logic [127:0]   REGS,
   output logic [7:0]     WR_STROBE,
   output logic           BUSY
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_WAIT   = 3'd2,
      S_ACK    = 3'd3,
      S_ERROR  = 3'd4,
      S_HOLD   = 3'd5
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [1:0]    as_sync;
   logic [1:0]    uds_sync;
   logic [1:0]    lds_sync;
   logic [1:0]    rw_sync;
   logic [2:0]    c7m_sync;
   logic [15:0]   d_sync1;
   logic [15:0]   d_sync2;
   logic          as_prev;

   logic          as_n;
   logic          as_fall;
   logic          c7m_fall;
   logic          hit;
   logic          do_write;

   logic [2:0]    idx_q;
   logic          wr_q;
   logic          uds_q;
   logic          lds_q;
   logic [3:0]    ws_cnt;
   logic [15:0]   to_cnt;

   logic [15:0]   regs [0:6];
   logic [15:0]   rd_data;

   // Bring the asynchronous bus strobes, bus clock and data into the PI_CLK domain
   always_ff @(posedge PI_CLK) begin
      if (SYS_RESET) begin
         as_sync  <= 2'b11;
         uds_sync <= 2'b11;
         lds_sync <= 2'b11;
         rw_sync  <= 2'b11;
         c7m_sync <= 3'b000;
         d_sync1  <= '0;
         d_sync2  <= '0;
         as_prev  <= 1'b1;
      end else begin
         as_sync  <= {as_sync[0], M68K_AS_n};
         uds_sync <= {uds_sync[0], M68K_UDS_n};
         lds_sync <= {lds_sync[0], M68K_LDS_n};
         rw_sync  <= {rw_sync[0], M68K_RW};
         c7m_sync <= {c7m_sync[1:0], M68K_CLK};
         d_sync1  <= M68K_D;
         d_sync2  <= d_sync1;
         as_prev  <= as_n;
      end
   end

   assign as_n     = as_sync[1];
   assign as_fall  = as_prev & ~as_n;
   assign c7m_fall = c7m_sync[2] & ~c7m_sync[1];
   // Address and FC are stable for the whole AS-low period, so they are compared directly
   assign hit      = !as_n && (M68K_A[23:4] == BASE_ADDR[23:4]) && (M68K_FC != 3'b111);

   // Bus-cycle sequencing; an AS release before HOLD is treated as a master abort
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (as_fall && hit) state_d = S_ACCEPT;
         S_ACCEPT: begin
            if (as_n)                            state_d = S_IDLE;
            else if (wr_q && (idx_q == 3'd7))    state_d = S_ERROR;
            else                                 state_d = S_WAIT;
         end
         S_WAIT: begin
            if (as_n)                    state_d = S_IDLE;
            else if (ws_cnt == 4'd0)     state_d = S_ACK;
         end
         S_ACK:    state_d = S_HOLD;
         S_ERROR:  state_d = S_HOLD;
         S_HOLD:   if (as_n || (to_cnt == 16'(TIMEOUT - 1))) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign do_write = (state_q == S_WAIT) && (state_d == S_ACK) && wr_q;

   // State register, per-cycle latches, wait/timeout counters and registered bus responses
   always_ff @(posedge PI_CLK) begin
      if (SYS_RESET) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         wr_q         <= 1'b0;
         uds_q        <= 1'b1;
         lds_q        <= 1'b1;
         ws_cnt       <= '0;
         to_cnt       <= '0;
         M68K_DTACK_n <= 1'b1;
         M68K_BERR_n  <= 1'b1;
         D_OE         <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && (state_d == S_ACCEPT)) begin
            idx_q  <= M68K_A[3:1];
            // AS with neither data strobe is handled as a write that touches no lane
            wr_q   <= !rw_sync[1] || (uds_sync[1] && lds_sync[1]);
            uds_q  <= uds_sync[1];
            lds_q  <= lds_sync[1];
            ws_cnt <= 4'(WAIT_STATES);
         end else if ((state_q == S_WAIT) && c7m_fall && (ws_cnt != 4'd0)) begin
            ws_cnt <= ws_cnt - 4'd1;
         end
         to_cnt <= (state_q == S_HOLD) ? to_cnt + 16'd1 : 16'd0;

         if (state_d == S_ACK)        M68K_DTACK_n <= 1'b0;
         else if (state_d == S_IDLE)  M68K_DTACK_n <= 1'b1;

         if (state_d == S_ERROR)      M68K_BERR_n <= 1'b0;
         else if (state_d == S_IDLE)  M68K_BERR_n <= 1'b1;

         D_OE <= !wr_q && ((state_d == S_WAIT) || (state_d == S_ACK) || (state_d == S_HOLD));
      end
   end

   // Register bank: byte-lane writes land together with a one-cycle strobe at ACK entry
   always_ff @(posedge PI_CLK) begin
      if (SYS_RESET) begin
         for (int i = 0; i < 7; i++) regs[i] <= '0;
         WR_STROBE <= '0;
      end else begin
         WR_STROBE <= '0;
         if (do_write) begin
            for (int i = 0; i < 7; i++) begin
               if (idx_q == 3'(i)) begin
                  if (!uds_q) regs[i][15:8] <= d_sync2[15:8];
                  if (!lds_q) regs[i][7:0]  <= d_sync2[7:0];
               end
            end
            WR_STROBE <= 8'd1 << idx_q;
         end
      end
   end

   // Flatten the bank; register 7 is the fixed ID word
   always_comb begin
      REGS = {ID_VALUE, 112'd0};
      for (int i = 0; i < 7; i++) REGS[16*i +: 16] = regs[i];
   end

   // Read mux drives both byte lanes regardless of which strobes were asserted
   always_comb begin
      rd_data = ID_VALUE;
      for (int i = 0; i < 7; i++) begin
         if (idx_q == 3'(i)) rd_data = regs[i];
      end
   end

   assign M68K_D = D_OE ? rd_data : 16'hzzzz;
   assign BUSY   = (state_q != S_IDLE);

endmodule
